ghist_manager: RTL and testbench
================================

# ghist_manager

Speculative global-history manager for the TAGE front end, directly upstream of the index/tag generator. Accepts one predicted branch per cycle, shifts its predicted direction into a 131-bit speculative history, and presents the pre-shift history plus PC with a one-cycle enable strobe for index/tag hashing. Holds an in-order checkpoint queue of in-flight branches and restores the history on a mispredicted resolution.

## Interface
- GlobLen, 131, history width; matches the generator's ghist input
- ADDRESS_SIZE, 32, PC width
- CKPT_DEPTH, 8, in-flight branch checkpoints; power of two
- CKPT_AW, 3, log2(CKPT_DEPTH)

Ports:
- CLK  in  1  clock
- reset  in  1  reset, synchronous, active-low; clock CLK
- pred_valid  in  1  new predicted branch offered
- pred_pc  in  ADDRESS_SIZE  its PC
- pred_taken  in  1  predicted direction
- pred_ready  out  1  branch accepted when pred_valid & pred_ready
- res_valid  in  1  oldest in-flight branch resolved
- res_taken  in  1  actual direction
- ghist  out  GlobLen  pre-shift history for the current lookup
- pc_addr  out  ADDRESS_SIZE  PC for the current lookup
- index_tag_enable  out  1  one-cycle lookup strobe
- flush  out  1  one-cycle mispredict pulse to fetch
- occupancy  out  CKPT_AW+1  in-flight branch count

## Operation
- Internal: spec_hist (GlobLen), checkpoint FIFO (entry = {hist, pred}), state RUN/RECOVER.
- pred_ready = reset & (state==RUN) & (occupancy != CKPT_DEPTH).
- Accept (RUN): push {spec_hist, pred_taken}; spec_hist <= {spec_hist[GlobLen-2:0], pred_taken}; ghist <= old spec_hist; pc_addr <= pred_pc; index_tag_enable <= 1.
- No accept: index_tag_enable <= 0; ghist and pc_addr hold.
- Resolve with occupancy 0: ignored, no state change.
- Resolve correct (res_taken == head.pred): pop; spec_hist unchanged.
- Resolve mispredict: spec_hist <= {head.hist[GlobLen-2:0], res_taken}; FIFO cleared, occupancy 0; flush <= 1; state -> RECOVER.
- RECOVER: pred_ready 0 for exactly one cycle; flush <= 0; -> RUN.
- Same-cycle accept and correct resolve: push and pop both occur; occupancy unchanged; when full, the pop does not raise pred_ready this cycle.
- Same-cycle pred_valid and mispredict: offered branch discarded regardless of pred_ready; no push, no strobe.
- Reset (any cycle, including mid-recovery): spec_hist, ghist, pc_addr, FIFO pointers, occupancy cleared to 0; index_tag_enable 0, flush 0, state RUN; pred_ready 0 while reset low.
- Occupancy arithmetic is CKPT_AW+1 bits; pointers wrap modulo CKPT_DEPTH.

## Timing
- Accept at cycle t: ghist, pc_addr, index_tag_enable valid at t+1; generator indices/tags at t+2.
- Back-to-back accepts: one strobe per cycle; each strobe carries the history including all older accepted predictions.
- Mispredict resolve at t: flush high at t+1; corrected spec_hist visible to the accept at t+2 (first possible).
- All outputs registered; pred_ready is the only combinational output.

## Configuration
- GHIST_PERF_CNT_EN defined: adds outputs branch_cnt (32) and mispred_cnt (32), counting accepted branches and mispredict resolves, saturating at 0xFFFFFFFF, reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package ghist_pkg: GlobLen, ADDRESS_SIZE, CKPT_DEPTH, CKPT_AW constants; state enum {RUN, RECOVER}; checkpoint entry struct {hist, pred}.
- One sub-module: ghist_ckpt_fifo (synchronous FIFO, push/pop/clear, occupancy).

## Test plan
- Reset, then accept pred_taken=1,0,1 on consecutive cycles, pc 0x100/0x104/0x108 -> strobes at t+1..t+3 with ghist 0x0, 0x1, 0x2; spec_hist low bits 0b101.
- Fill 8 branches without resolve -> pred_ready low, 9th pred_valid ignored; one correct resolve -> pred_ready high next cycle, occupancy 7.
- Accept taken=1 (head hist 0x5), resolve res_taken=0 -> flush pulse one cycle, occupancy 0, pred_ready low one cycle, next strobe ghist = 0xA.
- Resolve with occupancy 0 -> no flush, no state change; simultaneous accept and correct resolve at occupancy 4 -> stays 4.
- pred_valid in same cycle as mispredict -> no strobe, no push.
- Reset asserted during RECOVER -> all outputs 0; with GHIST_PERF_CNT_EN, after 3 accepts and 1 mispredict counters read 3 and 1.

Source files
------------

// File: rtl/ghist_pkg.sv
// Shared constants and types for the TAGE speculative global-history manager.
package ghist_pkg;

    localparam int GlobLen      = 131;
    localparam int ADDRESS_SIZE = 32;
    localparam int CKPT_DEPTH   = 8;
    localparam int CKPT_AW      = 3;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ghist_state_e;

    // History as it stood before this branch shifted in, plus its predicted direction.
    typedef struct packed {
        logic [GlobLen-1:0] hist;
        logic               pred;
    } ckpt_entry_t;

endpackage

// File: rtl/ghist_manager_if.sv
// Prediction/resolution handshake between the fetch front end and ghist_manager.
interface ghist_manager_if;
    import ghist_pkg::*;

    // A prediction transfers on a cycle where pred_valid & pred_ready are both high;
    // pred_pc/pred_taken must be stable while pred_valid is high. res_valid has no
    // ready: it always resolves the oldest in-flight branch and is ignored when none exist.
    logic                    pred_valid;
    logic [ADDRESS_SIZE-1:0] pred_pc;
    logic                    pred_taken;
    logic                    pred_ready;
    logic                    res_valid;
    logic                    res_taken;
    ghist_state_e            state_dbg;

    modport master (
        output pred_valid, pred_pc, pred_taken, res_valid, res_taken,
        input  pred_ready, state_dbg
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, res_valid, res_taken,
        output pred_ready, state_dbg
    );

endinterface

// File: rtl/ghist_ckpt_fifo.sv
// In-order checkpoint queue of in-flight branches with push, pop and whole-queue clear.
module ghist_ckpt_fifo
    import ghist_pkg::*;
(
    input  logic              CLK,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  ckpt_entry_t       wr_entry,
    output ckpt_entry_t       head,
    output logic [CKPT_AW:0]  occupancy
);

    localparam logic [CKPT_AW-1:0] PTR_ONE = 1;
    localparam logic [CKPT_AW:0]   OCC_ONE = 1;

    ckpt_entry_t        mem [CKPT_DEPTH];
    logic [CKPT_AW-1:0] wr_ptr;
    logic [CKPT_AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (!reset || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/ghist_manager.sv
// Speculative global-history manager feeding the TAGE index/tag generator.
// Optional GHIST_PERF_CNT_EN adds saturating branch/mispredict counters.
module ghist_manager
    import ghist_pkg::*;
(
    input  logic                    CLK,
    input  logic                    reset,
    ghist_manager_if.slave          br,
    output logic [GlobLen-1:0]      ghist,
    output logic [ADDRESS_SIZE-1:0] pc_addr,
    output logic                    index_tag_enable,
    output logic                    flush,
    output logic [CKPT_AW:0]        occupancy
`ifdef GHIST_PERF_CNT_EN
    ,
    output logic [31:0]             branch_cnt,
    output logic [31:0]             mispred_cnt
`endif
);

    localparam logic [CKPT_AW:0] OCC_FULL = CKPT_DEPTH;

    ghist_state_e       state;
    logic [GlobLen-1:0] spec_hist;
    ckpt_entry_t        head;
    ckpt_entry_t        push_entry;
    logic               res_fire;
    logic               mispredict;
    logic               resolve_ok;
    logic               accept;

    assign res_fire   = br.res_valid & (occupancy != '0);
    assign mispredict = res_fire & (br.res_taken != head.pred);
    assign resolve_ok = res_fire & ~mispredict;

    assign br.pred_ready = reset & (state == RUN) & (occupancy != OCC_FULL);
    // A mispredict in the same cycle squashes the offered branch: it was fetched down the wrong path.
    assign accept        = br.pred_valid & br.pred_ready & ~mispredict;
    assign br.state_dbg  = state;

    assign push_entry.hist = spec_hist;
    assign push_entry.pred = br.pred_taken;

    ghist_ckpt_fifo u_ckpt_fifo (
        .CLK       (CLK),
        .reset     (reset),
        .push      (accept),
        .pop       (resolve_ok),
        .clear     (mispredict),
        .wr_entry  (push_entry),
        .head      (head),
        .occupancy (occupancy)
    );

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state            <= RUN;
            spec_hist        <= '0;
            ghist            <= '0;
            pc_addr          <= '0;
            index_tag_enable <= 1'b0;
            flush            <= 1'b0;
        end else begin
            index_tag_enable <= accept;
            flush            <= mispredict;
            case (state)
                RUN: begin
                    if (mispredict) begin
                        // Rebuild from the checkpoint taken before the head branch, then shift in its real outcome.
                        spec_hist <= GlobLen'({head.hist, br.res_taken});
                        state     <= RECOVER;
                    end else if (accept) begin
                        spec_hist <= GlobLen'({spec_hist, br.pred_taken});
                        ghist     <= spec_hist;
                        pc_addr   <= br.pred_pc;
                    end
                end
                RECOVER: state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef GHIST_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (accept && branch_cnt != 32'hFFFF_FFFF)
                branch_cnt <= branch_cnt + 32'd1;
            if (mispredict && mispred_cnt != 32'hFFFF_FFFF)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ghist_manager.sv
// Directed self-checking bench for ghist_manager (define GHIST_PERF_CNT_EN to cover the counters).
module tb_ghist_manager;
    import ghist_pkg::*;

    logic                    CLK = 1'b0;
    logic                    reset;
    logic [GlobLen-1:0]      ghist;
    logic [ADDRESS_SIZE-1:0] pc_addr;
    logic                    index_tag_enable;
    logic                    flush;
    logic [CKPT_AW:0]        occupancy;
`ifdef GHIST_PERF_CNT_EN
    logic [31:0]             branch_cnt;
    logic [31:0]             mispred_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [GlobLen-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    ghist_manager_if br();

    ghist_manager dut (
        .CLK              (CLK),
        .reset            (reset),
        .br               (br),
        .ghist            (ghist),
        .pc_addr          (pc_addr),
        .index_tag_enable (index_tag_enable),
        .flush            (flush),
        .occupancy        (occupancy)
`ifdef GHIST_PERF_CNT_EN
        ,
        .branch_cnt       (branch_cnt),
        .mispred_cnt      (mispred_cnt)
`endif
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        br.pred_valid = 1'b0;
        br.pred_pc    = '0;
        br.pred_taken = 1'b0;
        br.res_valid  = 1'b0;
        br.res_taken  = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic drive_accept(input logic [ADDRESS_SIZE-1:0] pc, input logic taken);
        br.pred_valid = 1'b1;
        br.pred_pc    = pc;
        br.pred_taken = taken;
        tick();
        br.pred_valid = 1'b0;
    endtask

    task automatic drive_resolve(input logic taken);
        br.res_valid = 1'b1;
        br.res_taken = taken;
        tick();
        br.res_valid = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        br.pred_valid = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        n_vec++; if (ghist !== '0) begin n_err++; $display("FAIL reset_ghist got=%0h exp=0", ghist); end
        n_vec++; if (pc_addr !== '0) begin n_err++; $display("FAIL reset_pc got=%0h exp=0", pc_addr); end
        n_vec++; if (index_tag_enable !== 1'b0) begin n_err++; $display("FAIL reset_ite got=%0b exp=0", index_tag_enable); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%0b exp=0", flush); end
        n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        n_vec++; if (br.pred_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_low got=%0b exp=0", br.pred_ready); end
        n_vec++; if (br.state_dbg !== RUN) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", br.state_dbg, RUN); end
        br.pred_valid = 1'b0;
        reset = 1'b1;
        #1;
        n_vec++; if (br.pred_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_release got=%0b exp=1", br.pred_ready); end
    endtask

    task automatic test_basic;
        do_reset();
        drive_accept(32'h100, 1'b1);
        n_vec++; if (index_tag_enable !== 1'b1) begin n_err++; $display("FAIL basic_ite0 got=%0b exp=1", index_tag_enable); end
        n_vec++; if (ghist !== 131'h0) begin n_err++; $display("FAIL basic_ghist0 got=%0h exp=0", ghist); end
        n_vec++; if (pc_addr !== 32'h100) begin n_err++; $display("FAIL basic_pc0 got=%0h exp=100", pc_addr); end
        drive_accept(32'h104, 1'b0);
        n_vec++; if (ghist !== 131'h1) begin n_err++; $display("FAIL basic_ghist1 got=%0h exp=1", ghist); end
        n_vec++; if (pc_addr !== 32'h104) begin n_err++; $display("FAIL basic_pc1 got=%0h exp=104", pc_addr); end
        drive_accept(32'h108, 1'b1);
        n_vec++; if (ghist !== 131'h2) begin n_err++; $display("FAIL basic_ghist2 got=%0h exp=2", ghist); end
        n_vec++; if (occupancy !== 4'd3) begin n_err++; $display("FAIL basic_occ3 got=%0d exp=3", occupancy); end
        drive_accept(32'h10C, 1'b0);
        n_vec++; if (ghist !== 131'h5) begin n_err++; $display("FAIL basic_spec101 got=%0h exp=5", ghist); end
        tick();
        n_vec++; if (index_tag_enable !== 1'b0) begin n_err++; $display("FAIL basic_ite_idle got=%0b exp=0", index_tag_enable); end
        n_vec++; if (ghist !== 131'h5) begin n_err++; $display("FAIL basic_ghist_hold got=%0h exp=5", ghist); end
        n_vec++; if (pc_addr !== 32'h10C) begin n_err++; $display("FAIL basic_pc_hold got=%0h exp=10c", pc_addr); end
    endtask

    task automatic test_back_to_back;
        logic [5:0] dirs;
        logic [GlobLen-1:0] exp_g;
        dirs = 6'b001011;
        exp_q.push_back(131'h0);
        exp_q.push_back(131'h1);
        exp_q.push_back(131'h3);
        exp_q.push_back(131'h6);
        exp_q.push_back(131'hD);
        exp_q.push_back(131'h1A);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_accept(32'h300 + 32'(4 * i), dirs[i]);
            exp_g = exp_q.pop_front();
            n_vec++; if (index_tag_enable !== 1'b1 || ghist !== exp_g) begin
                n_err++; $display("FAIL b2b_strobe%0d ite=%0b ghist=%0h exp_ghist=%0h", i, index_tag_enable, ghist, exp_g);
            end
        end
        n_vec++; if (occupancy !== 4'd6) begin n_err++; $display("FAIL b2b_occ got=%0d exp=6", occupancy); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 8; i++)
            drive_accept(32'h200 + 32'(4 * i), i[0]);
        n_vec++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL full_occ got=%0d exp=8", occupancy); end
        n_vec++; if (br.pred_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got=%0b exp=0", br.pred_ready); end
        br.pred_valid = 1'b1;
        br.pred_pc    = 32'h220;
        br.pred_taken = 1'b1;
        tick();
        n_vec++; if (index_tag_enable !== 1'b0) begin n_err++; $display("FAIL full_9th_ite got=%0b exp=0", index_tag_enable); end
        n_vec++; if (pc_addr !== 32'h21C) begin n_err++; $display("FAIL full_9th_pc got=%0h exp=21c", pc_addr); end
        br.res_valid = 1'b1;
        br.res_taken = 1'b0;
        tick();
        br.res_valid  = 1'b0;
        br.pred_valid = 1'b0;
        #1;
        n_vec++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL full_pop_occ got=%0d exp=7", occupancy); end
        n_vec++; if (index_tag_enable !== 1'b0) begin n_err++; $display("FAIL full_pop_nopush got=%0b exp=0", index_tag_enable); end
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL full_pop_flush got=%0b exp=0", flush); end
        n_vec++; if (br.pred_ready !== 1'b1) begin n_err++; $display("FAIL full_pop_ready got=%0b exp=1", br.pred_ready); end
    endtask

    task automatic test_mispredict;
        do_reset();
        drive_accept(32'h100, 1'b1);
        drive_accept(32'h104, 1'b0);
        drive_accept(32'h108, 1'b1);
        drive_accept(32'h10C, 1'b1);
        drive_resolve(1'b1);
        drive_resolve(1'b0);
        drive_resolve(1'b1);
        n_vec++; if (occupancy !== 4'd1 || flush !== 1'b0) begin n_err++; $display("FAIL misp_pre occ=%0d flush=%0b exp occ=1 flush=0", occupancy, flush); end
        drive_resolve(1'b0);
        n_vec++; if (flush !== 1'b1) begin n_err++; $display("FAIL misp_flush got=%0b exp=1", flush); end
        n_vec++; if (occupancy !== '0) begin n_err++; $display("FAIL misp_occ got=%0d exp=0", occupancy); end
        n_vec++; if (br.pred_ready !== 1'b0) begin n_err++; $display("FAIL misp_ready got=%0b exp=0", br.pred_ready); end
        n_vec++; if (br.state_dbg !== RECOVER) begin n_err++; $display("FAIL misp_state got=%0d exp=%0d", br.state_dbg, RECOVER); end
        tick();
        n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL misp_flush_end got=%0b exp=0", flush); end
        n_vec++; if (br.pred_ready !== 1'b1) begin n_err++; $display("FAIL misp_ready_back got=%0b exp=1", br.pred_ready); end
        drive_accept(32'h500, 1'b0);
        n_vec++; if (index_tag_enable !== 1'b1 || ghist !== 131'hA) begin n_err++; $display("FAIL misp_restored ite=%0b ghist=%0h exp ghist=a", index_tag_enable, ghist); end
    endtask

    task automatic test_resolve_empty;
        do_reset();
        drive_resolve(1'b1);
        n_vec++; if (flush !== 1'b0 || occupancy !== '0) begin n_err++; $display("FAIL empty_res flush=%0b occ=%0d exp 0/0", flush, occupancy); end
        n_vec++; if (br.state_dbg !== RUN || br.pred_ready !== 1'b1) begin n_err++; $display("FAIL empty_state state=%0d ready=%0b exp RUN/1", br.state_dbg, br.pred_ready); end
        for (int i = 0; i < 4; i++)
            drive_accept(32'h600 + 32'(4 * i), 1'b1);
        n_vec++; if (ghist !== 131'h7) begin n_err++; $display("FAIL empty_ghist got=%0h exp=7", ghist); end
        br.pred_valid = 1'b1;
        br.pred_pc    = 32'h610;
        br.pred_taken = 1'b0;
        br.res_valid  = 1'b1;
        br.res_taken  = 1'b1;
        tick();
        idle_inputs();
        n_vec++; if (occupancy !== 4'd4) begin n_err++; $display("FAIL simul_occ got=%0d exp=4", occupancy); end
        n_vec++; if (index_tag_enable !== 1'b1 || ghist !== 131'hF) begin n_err++; $display("FAIL simul_strobe ite=%0b ghist=%0h exp ghist=f", index_tag_enable, ghist); end
        n_vec++; if (flush !== 1'b0 || pc_addr !== 32'h610) begin n_err++; $display("FAIL simul_misc flush=%0b pc=%0h exp 0/610", flush, pc_addr); end
    endtask

    task automatic test_pred_during_mispredict;
        do_reset();
        drive_accept(32'h700, 1'b1);
        drive_resolve(1'b1);
        drive_accept(32'h704, 1'b1);
        n_vec++; if (ghist !== 131'h1) begin n_err++; $display("FAIL pdm_pre got=%0h exp=1", ghist); end
        br.pred_valid = 1'b1;
        br.pred_pc    = 32'h708;
        br.pred_taken = 1'b1;
        br.res_valid  = 1'b1;
        br.res_taken  = 1'b0;
        tick();
        idle_inputs();
        n_vec++; if (index_tag_enable !== 1'b0) begin n_err++; $display("FAIL pdm_ite got=%0b exp=0", index_tag_enable); end
        n_vec++; if (pc_addr !== 32'h704) begin n_err++; $display("FAIL pdm_pc got=%0h exp=704", pc_addr); end
        n_vec++; if (occupancy !== '0 || flush !== 1'b1) begin n_err++; $display("FAIL pdm_nopush occ=%0d flush=%0b exp 0/1", occupancy, flush); end
        tick();
        drive_accept(32'h70C, 1'b0);
        n_vec++; if (ghist !== 131'h2) begin n_err++; $display("FAIL pdm_restored got=%0h exp=2", ghist); end
    endtask

    task automatic test_reset_in_recover;
        do_reset();
        drive_accept(32'h800, 1'b1);
        drive_accept(32'h804, 1'b1);
        drive_resolve(1'b1);
        drive_resolve(1'b0);
        n_vec++; if (br.state_dbg !== RECOVER) begin n_err++; $display("FAIL rir_pre state=%0d exp=%0d", br.state_dbg, RECOVER); end
        reset = 1'b0;
        tick();
        n_vec++; if (ghist !== '0 || pc_addr !== '0) begin n_err++; $display("FAIL rir_regs ghist=%0h pc=%0h exp 0/0", ghist, pc_addr); end
        n_vec++; if (index_tag_enable !== 1'b0 || flush !== 1'b0) begin n_err++; $display("FAIL rir_strobes ite=%0b flush=%0b exp 0/0", index_tag_enable, flush); end
        n_vec++; if (occupancy !== '0 || br.pred_ready !== 1'b0) begin n_err++; $display("FAIL rir_occ occ=%0d ready=%0b exp 0/0", occupancy, br.pred_ready); end
        n_vec++; if (br.state_dbg !== RUN) begin n_err++; $display("FAIL rir_state got=%0d exp=%0d", br.state_dbg, RUN); end
        reset = 1'b1;
        #1;
        drive_accept(32'h808, 1'b1);
        n_vec++; if (ghist !== 131'h0) begin n_err++; $display("FAIL rir_spec_cleared got=%0h exp=0", ghist); end
    endtask

`ifdef GHIST_PERF_CNT_EN
    task automatic test_perf_counters;
        do_reset();
        n_vec++; if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin n_err++; $display("FAIL perf_reset br=%0d mp=%0d exp 0/0", branch_cnt, mispred_cnt); end
        drive_accept(32'h900, 1'b1);
        drive_accept(32'h904, 1'b1);
        drive_accept(32'h908, 1'b1);
        drive_resolve(1'b0);
        tick();
        n_vec++; if (branch_cnt !== 32'd3) begin n_err++; $display("FAIL perf_branch got=%0d exp=3", branch_cnt); end
        n_vec++; if (mispred_cnt !== 32'd1) begin n_err++; $display("FAIL perf_mispred got=%0d exp=1", mispred_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_full();
        test_mispredict();
        test_resolve_empty();
        test_pred_during_mispredict();
        test_reset_in_recover();
`ifdef GHIST_PERF_CNT_EN
        test_perf_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
